// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin Common Data Bus arbiter with one holding slot per result port
// Optional per-requester grant/stall counters are built when CDB_ARB_PERF_EN is defined.
module cdb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 32,
    parameter int PHY_W   = 6,
    parameter int TAG_W   = 5,
    parameter int CNT_W   = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*TAG_W-1:0]     req_tag,
    input  logic [NUM_REQ*PHY_W-1:0]     req_phy_reg,
    input  logic [NUM_REQ*DATA_W-1:0]    req_value,
    output logic                         cdb_valid,
    output logic [TAG_W-1:0]             cdb_tag,
    output logic [PHY_W-1:0]             cdb_phy_reg,
    output logic [DATA_W-1:0]            cdb_value,
    output logic [$clog2(NUM_REQ)-1:0]   cdb_src
`ifdef CDB_ARB_PERF_EN
    ,
    output logic [NUM_REQ*CNT_W-1:0]     perf_grant_cnt,
    output logic [NUM_REQ*CNT_W-1:0]     perf_stall_cnt
`endif
);

    localparam int SRC_W = $clog2(NUM_REQ);
    localparam logic [SRC_W:0]   NUM_REQ_X = (SRC_W+1)'(NUM_REQ);
    localparam logic [SRC_W-1:0] LAST_IDX  = SRC_W'(NUM_REQ - 1);

    logic [NUM_REQ-1:0] slot_v;
    logic [TAG_W-1:0]   slot_tag   [NUM_REQ];
    logic [PHY_W-1:0]   slot_phy   [NUM_REQ];
    logic [DATA_W-1:0]  slot_value [NUM_REQ];

    logic [SRC_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] grant;
    logic [SRC_W-1:0]   gnt_idx;
    logic               any_grant;
    logic [SRC_W:0]     cand;
    logic [NUM_REQ-1:0] accept;

    // Rotating-priority scan starting at rr_ptr; first occupied slot wins.
    always_comb begin
        grant     = '0;
        gnt_idx   = '0;
        any_grant = 1'b0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (SRC_W+1)'(k);
            if (cand >= NUM_REQ_X) begin
                cand = cand - NUM_REQ_X;
            end
            if (!any_grant && slot_v[cand[SRC_W-1:0]]) begin
                any_grant                 = 1'b1;
                grant[cand[SRC_W-1:0]]    = 1'b1;
                gnt_idx                   = cand[SRC_W-1:0];
            end
        end
    end

    assign req_ready = ~slot_v | grant;
    assign accept    = req_valid & req_ready & {NUM_REQ{~flush}};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_v <= '0;
        end else if (flush) begin
            slot_v <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (accept[i]) begin
                    slot_v[i] <= 1'b1;
                end else if (grant[i]) begin
                    slot_v[i] <= 1'b0;
                end
            end
        end
    end

    // Payload needs no reset: it is only observed behind slot_v.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (accept[i]) begin
                slot_tag[i]   <= req_tag[i*TAG_W +: TAG_W];
                slot_phy[i]   <= req_phy_reg[i*PHY_W +: PHY_W];
                slot_value[i] <= req_value[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr      <= '0;
            cdb_valid   <= 1'b0;
            cdb_tag     <= '0;
            cdb_phy_reg <= '0;
            cdb_value   <= '0;
            cdb_src     <= '0;
        end else if (flush) begin
            cdb_valid <= 1'b0;
        end else if (any_grant) begin
            cdb_valid   <= 1'b1;
            cdb_tag     <= slot_tag[gnt_idx];
            cdb_phy_reg <= slot_phy[gnt_idx];
            cdb_value   <= slot_value[gnt_idx];
            cdb_src     <= gnt_idx;
            rr_ptr      <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
        end else begin
            cdb_valid <= 1'b0;
        end
    end

`ifdef CDB_ARB_PERF_EN
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_perf
        logic [CNT_W-1:0] grant_cnt;
        logic [CNT_W-1:0] stall_cnt;

        // A grant cancelled by flush never reaches the bus, so it is not counted.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                grant_cnt <= '0;
                stall_cnt <= '0;
            end else begin
                if (grant[g] && !flush && grant_cnt != {CNT_W{1'b1}}) begin
                    grant_cnt <= grant_cnt + 1'b1;
                end
                if (slot_v[g] && !grant[g] && stall_cnt != {CNT_W{1'b1}}) begin
                    stall_cnt <= stall_cnt + 1'b1;
                end
            end
        end

        assign perf_grant_cnt[g*CNT_W +: CNT_W] = grant_cnt;
        assign perf_stall_cnt[g*CNT_W +: CNT_W] = stall_cnt;
    end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed bench for cdb_arbiter (NUM_REQ=3, perf counters when CDB_ARB_PERF_EN)
module tb_cdb_arbiter;

    localparam int NUM_REQ = 3;
    localparam int DATA_W  = 32;
    localparam int PHY_W   = 6;
    localparam int TAG_W   = 5;
    localparam int CNT_W   = 2;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      flush;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*TAG_W-1:0]  req_tag;
    logic [NUM_REQ*PHY_W-1:0]  req_phy_reg;
    logic [NUM_REQ*DATA_W-1:0] req_value;
    logic                      cdb_valid;
    logic [TAG_W-1:0]          cdb_tag;
    logic [PHY_W-1:0]          cdb_phy_reg;
    logic [DATA_W-1:0]         cdb_value;
    logic [1:0]                cdb_src;
`ifdef CDB_ARB_PERF_EN
    logic [NUM_REQ*CNT_W-1:0]  perf_grant_cnt;
    logic [NUM_REQ*CNT_W-1:0]  perf_stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cdb_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .PHY_W(PHY_W), .TAG_W(TAG_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_tag(req_tag), .req_phy_reg(req_phy_reg), .req_value(req_value),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_phy_reg(cdb_phy_reg),
        .cdb_value(cdb_value), .cdb_src(cdb_src)
`ifdef CDB_ARB_PERF_EN
        , .perf_grant_cnt(perf_grant_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [TAG_W-1:0] tag,
                           input logic [PHY_W-1:0] phy, input logic [DATA_W-1:0] val);
        req_valid[i]                   = 1'b1;
        req_tag[i*TAG_W +: TAG_W]      = tag;
        req_phy_reg[i*PHY_W +: PHY_W]  = phy;
        req_value[i*DATA_W +: DATA_W]  = val;
    endtask

    task automatic do_reset();
        reset = 1'b1; flush = 1'b0; req_valid = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; req_valid = '0;
        req_tag = '0; req_phy_reg = '0; req_value = '0;
        step();
        checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", cdb_valid); end
        checks++; if (cdb_tag !== 5'd0) begin errors++; $display("FAIL reset_tag: got %0d want 0", cdb_tag); end
        checks++; if (cdb_value !== 32'd0) begin errors++; $display("FAIL reset_value: got %h want 0", cdb_value); end
        checks++; if (cdb_src !== 2'd0) begin errors++; $display("FAIL reset_src: got %0d want 0", cdb_src); end
        checks++; if (req_ready !== 3'b111) begin errors++; $display("FAIL reset_ready: got %b want 111", req_ready); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_single();
        set_req(1, 5'd4, 6'd12, 32'hDEAD_BEEF);
        step();
        req_valid = '0;
        checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL single_no_bypass: got %0b want 0", cdb_valid); end
        checks++; if (req_ready !== 3'b111) begin errors++; $display("FAIL single_ready: got %b want 111", req_ready); end
        step();
        checks++; if (cdb_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b want 1", cdb_valid); end
        checks++; if (cdb_tag !== 5'd4) begin errors++; $display("FAIL single_tag: got %0d want 4", cdb_tag); end
        checks++; if (cdb_phy_reg !== 6'd12) begin errors++; $display("FAIL single_phy: got %0d want 12", cdb_phy_reg); end
        checks++; if (cdb_value !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_value: got %h want deadbeef", cdb_value); end
        checks++; if (cdb_src !== 2'd1) begin errors++; $display("FAIL single_src: got %0d want 1", cdb_src); end
        step();
        checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL single_drop: got %0b want 0", cdb_valid); end
        checks++; if (cdb_tag !== 5'd4) begin errors++; $display("FAIL single_hold_tag: got %0d want 4", cdb_tag); end
    endtask

    // Entered with rr_ptr=2 left over from test_single.
    task automatic test_wrap();
        set_req(0, 5'd7, 6'd1, 32'h7);
        set_req(2, 5'd9, 6'd2, 32'h9);
        step();
        req_valid = '0;
        checks++; if (req_ready !== 3'b110) begin errors++; $display("FAIL wrap_ready: got %b want 110", req_ready); end
        step();
        checks++; if (cdb_valid !== 1'b1 || cdb_src !== 2'd2 || cdb_tag !== 5'd9) begin errors++; $display("FAIL wrap_first: got v=%0b src=%0d tag=%0d want v=1 src=2 tag=9", cdb_valid, cdb_src, cdb_tag); end
        step();
        checks++; if (cdb_valid !== 1'b1 || cdb_src !== 2'd0 || cdb_tag !== 5'd7) begin errors++; $display("FAIL wrap_second: got v=%0b src=%0d tag=%0d want v=1 src=0 tag=7", cdb_valid, cdb_src, cdb_tag); end
        set_req(0, 5'd3, 6'd3, 32'h3);
        set_req(2, 5'd5, 6'd5, 32'h5);
        step();
        req_valid = '0;
        step();
        checks++; if (cdb_src !== 2'd2 || cdb_tag !== 5'd5) begin errors++; $display("FAIL wrap_rr_end: got src=%0d tag=%0d want src=2 tag=5", cdb_src, cdb_tag); end
        step();
        checks++; if (cdb_src !== 2'd0 || cdb_tag !== 5'd3) begin errors++; $display("FAIL wrap_rr_next: got src=%0d tag=%0d want src=0 tag=3", cdb_src, cdb_tag); end
        step();
        checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL wrap_idle: got %0b want 0", cdb_valid); end
    endtask

    task automatic test_contention();
        do_reset();
        set_req(0, 5'd10, 6'd20, 32'hA0);
        set_req(1, 5'd11, 6'd21, 32'hA1);
        set_req(2, 5'd12, 6'd22, 32'hA2);
        step();
        req_valid = '0;
        checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL cont_ready0: got %b want 001", req_ready); end
        step();
        checks++; if (cdb_valid !== 1'b1 || cdb_src !== 2'd0 || cdb_tag !== 5'd10) begin errors++; $display("FAIL cont_g0: got v=%0b src=%0d tag=%0d want v=1 src=0 tag=10", cdb_valid, cdb_src, cdb_tag); end
        checks++; if (req_ready !== 3'b011) begin errors++; $display("FAIL cont_ready1: got %b want 011", req_ready); end
        step();
        checks++; if (cdb_valid !== 1'b1 || cdb_src !== 2'd1 || cdb_value !== 32'hA1) begin errors++; $display("FAIL cont_g1: got v=%0b src=%0d val=%h want v=1 src=1 val=a1", cdb_valid, cdb_src, cdb_value); end
        step();
        checks++; if (cdb_valid !== 1'b1 || cdb_src !== 2'd2 || cdb_phy_reg !== 6'd22) begin errors++; $display("FAIL cont_g2: got v=%0b src=%0d phy=%0d want v=1 src=2 phy=22", cdb_valid, cdb_src, cdb_phy_reg); end
        step();
        checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL cont_idle: got %0b want 0", cdb_valid); end
    endtask

    task automatic test_back_to_back();
        logic [TAG_W-1:0] exp_tag;
        do_reset();
        for (int n = 0; n < 4; n++) begin
            if (n < 3) set_req(0, 5'(n + 1), 6'(n), 32'(n + 100));
            else req_valid = '0;
            step();
            checks++; if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL b2b_ready n=%0d: got %0b want 1", n, req_ready[0]); end
            if (n > 0) begin
                exp_tag = 5'(n);
                checks++; if (cdb_valid !== 1'b1 || cdb_tag !== exp_tag || cdb_src !== 2'd0) begin errors++; $display("FAIL b2b_bcast n=%0d: got v=%0b tag=%0d src=%0d want v=1 tag=%0d src=0", n, cdb_valid, cdb_tag, cdb_src, exp_tag); end
            end
        end
        step();
        checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %0b want 0", cdb_valid); end
    endtask

    task automatic test_flush();
        do_reset();
        set_req(0, 5'd20, 6'd1, 32'h20);
        set_req(2, 5'd22, 6'd2, 32'h22);
        step();
        req_valid = '0;
        set_req(1, 5'd21, 6'd3, 32'h21);
        flush = 1'b1;
        step();
        flush = 1'b0;
        req_valid = '0;
        checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %0b want 0", cdb_valid); end
        checks++; if (req_ready !== 3'b111) begin errors++; $display("FAIL flush_ready: got %b want 111", req_ready); end
        for (int n = 0; n < 3; n++) begin
            step();
            checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL flush_stale n=%0d: got v=%0b tag=%0d want v=0", n, cdb_valid, cdb_tag); end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        set_req(0, 5'd30, 6'd30, 32'h30);
        set_req(1, 5'd31, 6'd31, 32'h31);
        step();
        req_valid = '0;
        step();
        checks++; if (cdb_valid !== 1'b1 || cdb_tag !== 5'd30) begin errors++; $display("FAIL areset_pre: got v=%0b tag=%0d want v=1 tag=30", cdb_valid, cdb_tag); end
        #2 reset = 1'b1;
        #1;
        checks++; if (cdb_valid !== 1'b0 || cdb_tag !== 5'd0) begin errors++; $display("FAIL areset_now: got v=%0b tag=%0d want v=0 tag=0", cdb_valid, cdb_tag); end
        checks++; if (req_ready !== 3'b111) begin errors++; $display("FAIL areset_ready: got %b want 111", req_ready); end
        step();
        reset = 1'b0;
        step();
        checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL areset_after: got %0b want 0", cdb_valid); end
    endtask

`ifdef CDB_ARB_PERF_EN
    task automatic test_perf();
        do_reset();
        set_req(0, 5'd1, 6'd1, 32'h1);
        set_req(1, 5'd2, 6'd2, 32'h2);
        set_req(2, 5'd3, 6'd3, 32'h3);
        step();
        req_valid = '0;
        step();
        step();
        step();
        checks++; if (perf_stall_cnt[2*CNT_W +: CNT_W] !== 2'd2) begin errors++; $display("FAIL perf_stall2: got %0d want 2", perf_stall_cnt[2*CNT_W +: CNT_W]); end
        checks++; if (perf_stall_cnt[1*CNT_W +: CNT_W] !== 2'd1) begin errors++; $display("FAIL perf_stall1: got %0d want 1", perf_stall_cnt[1*CNT_W +: CNT_W]); end
        checks++; if (perf_grant_cnt !== 6'b01_01_01) begin errors++; $display("FAIL perf_grant_each: got %b want 010101", perf_grant_cnt); end
        for (int n = 0; n < 5; n++) begin
            set_req(0, 5'(n), 6'(n), 32'(n));
            step();
        end
        req_valid = '0;
        step();
        step();
        checks++; if (perf_grant_cnt[0 +: CNT_W] !== 2'd3) begin errors++; $display("FAIL perf_grant_sat: got %0d want 3", perf_grant_cnt[0 +: CNT_W]); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_contention();
        test_back_to_back();
        test_flush();
        test_async_reset();
`ifdef CDB_ARB_PERF_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
